uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, 3-sample majority voting
// and a fixed bit-period table for a 50 MHz clock.
module uart_rx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = 18;
  localparam int unsigned IDX_W = 3;

  localparam logic [CNT_W-1:0] N_300   = 18'd166667;
  localparam logic [CNT_W-1:0] N_1200  = 18'd41667;
  localparam logic [CNT_W-1:0] N_2400  = 18'd20833;
  localparam logic [CNT_W-1:0] N_9600  = 18'd5208;
  localparam logic [CNT_W-1:0] N_19200 = 18'd2604;
  localparam logic [CNT_W-1:0] N_115K  = 18'd434;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_meta, rx_s, rx_prev;
  logic [1:0]       sync_vld;
  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] n_reg, n_nx, n_sel_c, half_c;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       shreg, shreg_nx, data_nx;
  logic [1:0]       smp, smp_nx;
  logic             rx_done_nx, frame_err_nx;
  logic             fall_c, maj_c, last_c, at_lo_c, at_mid_c, at_dec_c;

  // Bit-period lookup; unlisted codes fall back to 9600 baud
  always_comb begin
    case (baud_set)
      3'b000:  n_sel_c = N_300;
      3'b001:  n_sel_c = N_1200;
      3'b010:  n_sel_c = N_2400;
      3'b011:  n_sel_c = N_9600;
      3'b100:  n_sel_c = N_19200;
      3'b101:  n_sel_c = N_115K;
      default: n_sel_c = N_9600;
    endcase
  end

  assign half_c   = n_reg >> 1;
  assign last_c   = (cnt == n_reg - 18'd1);
  assign at_lo_c  = (cnt == half_c - 18'd1);
  assign at_mid_c = (cnt == half_c);
  assign at_dec_c = (cnt == half_c + 18'd1);
  assign maj_c    = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  // rx_prev stays 0 until the synchronizer holds real line samples, so a line
  // that is already low when reset releases is not mistaken for a start edge
  assign fall_c   = rx_prev & ~rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      sync_vld <= 2'b00;
      rx_prev  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      sync_vld <= {sync_vld[0], 1'b1};
      rx_prev  <= sync_vld[1] ? rx_s : 1'b0;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    n_nx         = n_reg;
    idx_nx       = idx;
    shreg_nx     = shreg;
    smp_nx       = smp;
    data_nx      = data;
    rx_done_nx   = 1'b0;
    frame_err_nx = 1'b0;

    if (state != IDLE) begin
      cnt_nx = last_c ? '0 : cnt + 18'd1;
      if (at_lo_c)  smp_nx[0] = rx_s;
      if (at_mid_c) smp_nx[1] = rx_s;
    end

    case (state)
      IDLE: begin
        if (fall_c) begin
          state_nx = START;
          cnt_nx   = '0;
          n_nx     = n_sel_c;
          idx_nx   = '0;
        end
      end
      START: begin
        if (at_dec_c && maj_c) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (last_c) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (at_dec_c) shreg_nx = {maj_c, shreg[7:1]};
        if (last_c) begin
          idx_nx = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (at_dec_c) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          if (maj_c) begin
            data_nx    = shreg;
            rx_done_nx = 1'b1;
          end else begin
            frame_err_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      n_reg     <= N_9600;
      idx       <= '0;
      shreg     <= 8'h00;
      smp       <= 2'b00;
      data      <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      n_reg     <= n_nx;
      idx       <= idx_nx;
      shreg     <= shreg_nx;
      smp       <= smp_nx;
      data      <= data_nx;
      rx_done   <= rx_done_nx;
      frame_err <= frame_err_nx;
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level model predicting pulse kind, data and arrival
// cycle for every frame sent; one negedge process compares against it.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [2:0] baud_set;
  logic [7:0] data;
  logic       rx_done, frame_err, busy;

  uart_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .baud_set  (baud_set),
    .data      (data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  exp_t       cur;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_pulse = 0;
  int         n_err = 0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d at cycle %0d", name, act, lo, hi, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, n cycles per bit; the predicted pulse lands at
  // 2 + 9n + n/2 + 2 cycles after the first clock edge that sees the start bit
  task automatic send_frame(input logic [7:0] d, input bit stop, input int n,
                            input bit expect_it, input int stop_len, output int p);
    p = cyc;
    if (expect_it) exp_q.push_back('{!stop, d, p + 1 + 2 + 9 * n + n / 2 + 2});
    rx = 1'b0;
    wait_cycles(n);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(n);
    end
    rx = stop;
    wait_cycles(stop_len);
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge clk) begin
    if (!reset_n) begin
      model_data = 8'h00;
      chk("reset_state", 32'({rx_done, frame_err, busy, data}), 32'h0);
    end else begin
      chk("done_err_exclusive", 32'(rx_done & frame_err), 32'h0);
      if (rx_done || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({rx_done, frame_err}), 32'h0);
        end else begin
          cur = exp_q.pop_front();
          last_pulse = cyc;
          chk("pulse_kind", 32'(frame_err), 32'(cur.is_err));
          chk_rng("pulse_time", cyc, cur.t - 1, cur.t + 1);
          if (!cur.is_err) begin
            model_data = cur.d;
            got_q.push_back(data);
          end else begin
            n_err++;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].t + 1) begin
        checks++;
        errors++;
        $display("FAIL pulse_missing: none by cycle %0d, expected near %0d", cyc, exp_q[0].t);
        cur = exp_q.pop_front();
      end
      chk("data", 32'(data), 32'(model_data));
    end
  end

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         p;
    int         gap;
    logic [7:0] d;
    bit         sb;
    logic [7:0] b2b [3];
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h55;

    reset_n  = 1'b1;
    rx       = 1'b1;
    baud_set = 3'b011;
    #1 reset_n = 1'b0;
    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(10);
    chk("idle_busy", 32'(busy), 32'h0);

    // 0xA5 at 9600 baud, rate select switched to 115200 during bit 2
    fork
      send_frame(8'hA5, 1'b1, 5208, 1'b1, 2624, p);
      begin
        wait_cycles(3 * 5208 + 100);
        baud_set = 3'b101;
      end
    join
    wait_cycles(20);
    chk("a5_data", 32'(data), 32'h0000_00A5);
    chk_rng("a5_latency", last_pulse - p, 49480, 49482);

    // Bad stop bit at 115200, line then held low
    send_frame(8'h3C, 1'b0, 434, 1'b1, 2 * 434, p);
    chk("err_no_retrigger_busy", 32'(busy), 32'h0);
    chk("err_data_held", 32'(data), 32'h0000_00A5);
    chk("err_pulses", 32'(n_err), 32'h1);
    rx = 1'b1;
    wait_cycles(20);

    // Back-to-back frames, no idle gap
    got_q.delete();
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, 434, 1'b1, 434, p);
    wait_cycles(20);
    chk("b2b_count", 32'(got_q.size()), 32'h3);
    for (int i = 0; i < 3; i++)
      if (got_q.size() > i) chk("b2b_data", 32'(got_q[i]), 32'(b2b[i]));

    // Slow-rate frame aborted by reset; line low through release
    baud_set = 3'b000;
    rx = 1'b0;
    wait_cycles(500);
    chk("slow_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(10);
    chk("slow_rst_no_retrigger", 32'(busy), 32'h0);
    rx = 1'b1;
    wait_cycles(20);

    // 0x81 with reset during bit 4, then a clean 0x81
    baud_set = 3'b101;
    fork
      send_frame(8'h81, 1'b1, 434, 1'b0, 434, p);
      begin
        wait_cycles(5 * 434 + 200);
        reset_n = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(50);
        chk("rst_no_retrigger", 32'(busy), 32'h0);
      end
    join
    wait_cycles(20);
    chk("rst_data", 32'(data), 32'h0);
    send_frame(8'h81, 1'b1, 434, 1'b1, 434, p);
    wait_cycles(20);
    chk("after_rst_data", 32'(data), 32'h0000_0081);

    // False start at 9600: 1000 low cycles then high
    baud_set = 3'b011;
    wait_cycles(5);
    rx = 1'b0;
    wait_cycles(500);
    chk("false_start_busy_early", 32'(busy), 32'h1);
    wait_cycles(500);
    rx = 1'b1;
    wait_cycles(1500);
    chk("false_start_busy_late", 32'(busy), 32'h1);
    wait_cycles(200);
    chk("false_start_idle", 32'(busy), 32'h0);

    // Randomized frames at 115200
    baud_set = 3'b101;
    wait_cycles(5);
    for (int k = 0; k < 2; k++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      send_frame(d, sb, 434, 1'b1, 434, p);
      gap = sb ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      if (gap > 0) begin
        rx = 1'b1;
        wait_cycles(gap);
      end
    end
    rx = 1'b1;
    wait_cycles(200);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
